// File: rtl/multi_timer_if.sv
// Control/status bundle for the multi-channel millisecond timer.
// master drives commands, slave is the timer block.
interface multi_timer_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
);
   logic [NUM_CH-1:0]       start;
   logic [NUM_CH-1:0]       stop;
   logic [NUM_CH-1:0]       pause;
   logic [NUM_CH-1:0]       periodic;
   logic [NUM_CH*CNT_W-1:0] load_ms;
   logic [NUM_CH-1:0]       busy;
   logic [NUM_CH-1:0]       done;
   logic [NUM_CH*CNT_W-1:0] remaining;

   modport master (
      output start, stop, pause, periodic, load_ms,
      input  busy, done, remaining
   );

   modport slave (
      input  start, stop, pause, periodic, load_ms,
      output busy, done, remaining
   );
endinterface

// File: rtl/multi_timer.sv
// Independent millisecond countdown channels, each with a cycle
// prescaler, one-shot/periodic modes, pause and abort.
module multi_timer #(
   parameter int CLK_FREQ_MHZ = 50,
   parameter int NUM_CH       = 4,
   parameter int CNT_W        = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   multi_timer_if.slave bus
);
   localparam int TICKS = CLK_FREQ_MHZ * 1000;
   localparam int PW    = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICKS - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSED
   } state_e;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_e           st_q;
      logic [CNT_W-1:0] cnt_q;
      logic [PW-1:0]    pre_q;
      logic             done_q;
      logic             busy_q;
      logic [CNT_W-1:0] load;

      assign load = bus.load_ms[i*CNT_W +: CNT_W];

      // Per-channel FSM: stop > start > pause > prescaler tick.
      // Leaving PAUSED ticks in the same cycle so the frozen time
      // equals exactly the number of cycles pause was high.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            pre_q  <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
         end else begin
            done_q <= 1'b0;
            if (bus.stop[i]) begin
               st_q   <= IDLE;
               busy_q <= 1'b0;
               cnt_q  <= '0;
               pre_q  <= '0;
            end else if (bus.start[i]) begin
               pre_q <= '0;
               if (load == '0) begin
                  st_q   <= IDLE;
                  busy_q <= 1'b0;
                  cnt_q  <= '0;
                  done_q <= 1'b1;
               end else begin
                  st_q   <= RUN;
                  busy_q <= 1'b1;
                  cnt_q  <= load;
               end
            end else if (st_q != IDLE) begin
               if (bus.pause[i]) begin
                  st_q <= PAUSED;
               end else begin
                  st_q <= RUN;
                  if (pre_q == PMAX) begin
                     pre_q <= '0;
                     if (cnt_q == CNT_W'(1)) begin
                        done_q <= 1'b1;
                        if (bus.periodic[i] && load != '0) begin
                           cnt_q <= load;
                        end else begin
                           st_q   <= IDLE;
                           busy_q <= 1'b0;
                           cnt_q  <= '0;
                        end
                     end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                     end
                  end else begin
                     pre_q <= pre_q + 1'b1;
                  end
               end
            end
         end
      end

      assign bus.busy[i]                   = busy_q;
      assign bus.done[i]                   = done_q;
      assign bus.remaining[i*CNT_W +: CNT_W] = cnt_q;
   end
endmodule
